ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: the sending side of the keyboard link whose receive side already feeds `kb_data`/`kb_done`. It serialises one command byte to the keyboard (set LEDs 0xED, reset 0xFF, enable 0xF4, typematic 0xF3, …) using the PS/2 host request-to-send sequence, with odd parity, device ACK check and timeout. It drives the shared PS2_CLK/PS2_DAT pins open-drain via two pull-low enables. The top level ties them as `pin = oe ? 0 : Z` and gates the receiver's `done` while `busy` is high.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 2500: clock-low hold before start bit; 100 µs at 25 MHz.
- `TIMEOUT_CYCLES`, 375000: maximum time from clock release to ACK complete; 15 ms at 25 MHz.

Ports:
- `clock`  in  1  system clock, 25 MHz; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `send`  in  1  one-cycle request; accepted only when `busy`=0.
- `data`  in  8  byte to send; sampled in the accept cycle.
- `ps_clock_in`  in  1  PS2_CLK pin level; asynchronous.
- `ps_data_in`  in  1  PS2_DAT pin level; asynchronous.
- `ps_clock_oe`  out  1  1 = pull PS2_CLK low.
- `ps_data_oe`  out  1  1 = pull PS2_DAT low.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at the end of a transfer, successful or failed.
- `error`  out  1  last transfer failed (no ACK or timeout); valid from `done` until the next accepted `send`.

## Operation
- Both pin inputs pass through 2-flop synchronisers. A falling edge is synced clock 1→0 between consecutive cycles.
- Frame shift register (10 bits, LSB first): data[7:0], parity = ~^data (odd), stop = 1.
- FSM states:
  - IDLE: both oe=0, busy=0. On `send`: latch the frame, clear `error`, set `busy`=1 and `ps_clock_oe`=1, go to INHIBIT.
  - INHIBIT: count INHIBIT_CYCLES. On terminal count set `ps_data_oe`=1 (start bit 0) and go to START.
  - START: one cycle. Set `ps_clock_oe`=0, clear the timeout counter, bit counter=0, go to BITS.
  - BITS: on each falling edge, `ps_data_oe` ← ~frame[0], shift right, increment the bit counter. After the 10th edge (stop bit, data released) go to ACK.
  - ACK: on the next falling edge, sample synced data. 0 = ACK OK, 1 = NACK. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock and synced data are both 1. Then pulse `done`, set `error` = NACK, go to IDLE.
- Timeout: the counter runs in BITS, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES forces both oe=0, pulses `done` with `error`=1, and returns to IDLE.
- `send` while `busy`=1 is ignored. `data` changes after accept have no effect.

## Timing
- Reset values: `ps_clock_oe`=0, `ps_data_oe`=0, `busy`=0, `done`=0, `error`=0, state IDLE. Asserting reset mid-transfer releases both lines immediately (asynchronously), with no `done` pulse.
- Accept cycle is N. `busy` and `ps_clock_oe` rise at N+1.
- `ps_data_oe` rises at N+1+INHIBIT_CYCLES. `ps_clock_oe` falls one cycle later.
- The `ps_data_oe` update lands 3 cycles after the pin falling edge (2 sync + 1 register). This is well inside the device's ≥30 µs clock-low phase.
- `done` is high exactly one cycle. `busy` falls in the same cycle as `done`. A new `send` can be accepted the cycle after `done`.
- Total line hold for one byte ≈ 100 µs + 11 device clocks (~1 ms at 10–16.7 kHz).

## Test plan
- Send 0xED with a device model clocking at 15 kHz that ACKs. Required: clock held low exactly 2500 cycles, then start bit. Bits on the line are 1,0,1,1,0,1,1,1, parity 1, stop 1. `done` pulses once, `error`=0, `busy` then low.
- Send 0xF4. Required: parity bit 0 (five ones) and bits 0,0,1,0,1,1,1,1. Device sees a valid frame.
- Device leaves data high on the ACK clock (NACK). Required: `done` with `error`=1, both oe=0 afterwards.
- Device never clocks after the clock is released. Required: at 375000 cycles after START, `done` pulses with `error`=1, both oe=0, `busy`=0.
- Pulse `send` with 0x00 during an active 0xFF transfer. Required: ignored, and the frame carries 0xFF.
- Assert `reset_n`=0 during BITS. Required: both oe and `busy` go to 0 with no clock edge needed. After release, a new 0xFF send completes normally.

Source files
------------

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: sends one byte using the request-to-send sequence.
// It drives PS2_CLK and PS2_DAT open-drain through pull-low enables, checks the device ACK, and enforces a timeout.
module ps2_tx #(
   parameter int unsigned INHIBIT_CYCLES = 2500,
   parameter int unsigned TIMEOUT_CYCLES = 375000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       send,
   input  logic [7:0] data,
   input  logic       ps_clock_in,
   input  logic       ps_data_in,
   output logic       ps_clock_oe,
   output logic       ps_data_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_BITS,
      S_ACK,
      S_WAIT
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic          r_clk_s1;
   logic          r_clk_s2;
   logic          r_clk_prev;
   logic          r_dat_s1;
   logic          r_dat_s2;
   logic [9:0]    r_frame;
   logic          r_bit_oe;
   logic [3:0]    r_bit_cnt;
   logic [IW-1:0] r_inh_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          r_nack;
   logic          r_done;
   logic          r_error;

   logic          w_fall;
   logic          w_timed;
   logic          w_timeout;
   logic          w_line_idle;

   assign w_fall      = r_clk_prev & ~r_clk_s2;
   assign w_timed     = (r_state == S_BITS) || (r_state == S_ACK) || (r_state == S_WAIT);
   assign w_timeout   = w_timed && (r_to_cnt == TO_LAST);
   assign w_line_idle = r_clk_s2 & r_dat_s2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (send) w_next = S_INHIBIT;
         end
         S_INHIBIT: begin
            if (r_inh_cnt == INH_LAST) w_next = S_START;
         end
         S_START: begin
            w_next = S_BITS;
         end
         S_BITS: begin
            if (w_timeout)                           w_next = S_IDLE;
            else if (w_fall && (r_bit_cnt == 4'd9))  w_next = S_ACK;
         end
         S_ACK: begin
            if (w_timeout)   w_next = S_IDLE;
            else if (w_fall) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_timeout || w_line_idle) w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // The line enables decode from state, so an asynchronous reset releases both pins at once.
   always_comb begin
      ps_clock_oe = 1'b0;
      ps_data_oe  = 1'b0;
      busy        = 1'b1;
      unique case (r_state)
         S_IDLE:    busy        = 1'b0;
         S_INHIBIT: ps_clock_oe = 1'b1;
         S_START: begin
            ps_clock_oe = 1'b1;
            ps_data_oe  = 1'b1;
         end
         S_BITS:    ps_data_oe  = r_bit_oe;
         default:   ;
      endcase
   end

   assign done  = r_done;
   assign error = r_error;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_frame    <= '0;
         r_bit_oe   <= 1'b0;
         r_bit_cnt  <= '0;
         r_inh_cnt  <= '0;
         r_to_cnt   <= '0;
         r_nack     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_clk_s1   <= ps_clock_in;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= ps_data_in;
         r_dat_s2   <= r_dat_s1;
         r_done     <= 1'b0;
         r_inh_cnt  <= (r_state == S_INHIBIT) ? r_inh_cnt + IW'(1) : '0;
         r_to_cnt   <= w_timed ? r_to_cnt + TW'(1) : '0;

         if ((r_state == S_IDLE) && send) begin
            r_frame <= {1'b1, ~^data, data};
            r_error <= 1'b0;
         end

         // The start bit stays asserted through BITS until the first device falling edge.
         if (r_state == S_START) begin
            r_bit_oe  <= 1'b1;
            r_bit_cnt <= '0;
            r_nack    <= 1'b0;
         end

         if ((r_state == S_BITS) && w_fall) begin
            r_bit_oe  <= ~r_frame[0];
            r_frame   <= {1'b0, r_frame[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end

         if ((r_state == S_ACK) && w_fall) begin
            r_nack <= r_dat_s2;
         end

         if (w_timed && (w_next == S_IDLE)) begin
            r_done  <= 1'b1;
            r_error <= w_timeout | r_nack;
         end
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: an open-drain PS/2 device model plus a timeline model of the host outputs.
// The timeline model is derived from the accept cycle and the device clock edges.
module tb_ps2_tx;

   localparam int INH = 40;
   localparam int TO  = 3000;
   localparam int BIG = 32'h3fff_ffff;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       send    = 1'b0;
   logic [7:0] data    = '0;
   logic       ps_clock_oe, ps_data_oe, busy, done, error;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       pin_clk, pin_dat;

   assign pin_clk = ~(ps_clock_oe | dev_clk_low);
   assign pin_dat = ~(ps_data_oe  | dev_dat_low);

   ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .send        (send),
      .data        (data),
      .ps_clock_in (pin_clk),
      .ps_data_in  (pin_dat),
      .ps_clock_oe (ps_clock_oe),
      .ps_data_oe  (ps_data_oe),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model of the current transfer: accept cycle, device falling-edge cycles, frame bits.
   logic       m_act      = 1'b0;
   int         m_A        = 0;
   int         m_D_ok     = BIG;
   int         m_f [10];
   logic [9:0] m_frame    = '0;
   logic       m_nack     = 1'b0;
   logic       m_err_hold = 1'b0;

   function automatic int model_done_cycle();
      int d_to;
      d_to = m_A + 2 + INH + TO;
      return (m_D_ok < d_to) ? m_D_ok : d_to;
   endfunction

   // Returns {busy, ps_clock_oe, ps_data_oe, done, error} expected in cycle c.
   function automatic logic [4:0] model_at(input int c);
      int         d;
      int         k;
      logic       res;
      logic [4:0] r;
      d   = model_done_cycle();
      res = (d == m_A + 2 + INH + TO) ? 1'b1 : m_nack;
      r   = {4'b0000, m_err_hold};
      if (!m_act || c <= m_A) return r;
      if (c < d) begin
         k = 0;
         for (int j = 0; j < 10; j++) if (m_f[j] + 3 <= c) k++;
         r[4] = 1'b1;
         r[3] = (c <= m_A + 1 + INH);
         if (c < m_A + 1 + INH) r[2] = 1'b0;
         else if (k == 0)       r[2] = 1'b1;
         else                   r[2] = ~m_frame[k-1];
         r[1] = 1'b0;
         r[0] = 1'b0;
      end else begin
         r = {3'b000, (c == d), res};
      end
      return r;
   endfunction

   logic [4:0] cmp_exp;
   always @(negedge clock) begin
      cmp_exp = model_at(cyc);
      chk("outputs{busy,clk_oe,dat_oe,done,error}",
          {27'd0, busy, ps_clock_oe, ps_data_oe, done, error}, {27'd0, cmp_exp});
   end

   task automatic pulse_send(input logic [7:0] b, output logic acc);
      logic [4:0] e;
      @(posedge clock); #1;
      data = b;
      send = 1'b1;
      e    = model_at(cyc);
      acc  = ~e[4];
      if (acc) begin
         m_err_hold = e[0];
         m_act      = 1'b1;
         m_A        = cyc;
         m_D_ok     = BIG;
         m_nack     = 1'b0;
         m_frame    = {1'b1, (($countones(b) % 2) == 0), b};
         for (int j = 0; j < 10; j++) m_f[j] = BIG;
      end
      @(posedge clock); #1;
      send = 1'b0;
      data = 8'($urandom);
   endtask

   task automatic device(input int nclk, input int half, input logic ack,
                         output logic [9:0] rx, output int inh, output logic start_ok, output logic rts);
      int t;
      rx = '0; inh = 0; start_ok = 1'b0; rts = 1'b0; t = 0;
      while (t < INH + 100) begin
         if (pin_dat == 1'b0 && pin_clk == 1'b1) begin
            rts = 1'b1;
            break;
         end
         if (ps_clock_oe && !ps_data_oe) inh++;
         @(posedge clock); #1;
         t++;
      end
      if (!rts) return;
      repeat (half) @(posedge clock);
      #1;
      start_ok = ~pin_dat;
      for (int i = 0; i < nclk; i++) begin
         dev_clk_low = 1'b1;
         if (i < 10) m_f[i] = cyc;
         repeat (half) @(posedge clock);
         #1;
         dev_clk_low = 1'b0;
         if (i < 10) rx[i] = pin_dat;
         if (i == 9) dev_dat_low = ack;
         if (i == 10) begin
            dev_dat_low = 1'b0;
            m_D_ok      = cyc + 3;
         end
         repeat (half) @(posedge clock);
         #1;
      end
   endtask

   task automatic run_xfer(input logic [7:0] b, input int half, input logic ack, input int nclk,
                           output logic [9:0] rx, output int inh, output logic start_ok, output logic rts);
      logic acc;
      int   t;
      pulse_send(b, acc);
      if (acc) m_nack = ~ack;
      device(nclk, half, ack, rx, inh, start_ok, rts);
      t = 0;
      while (cyc <= model_done_cycle() + 1 && t < 2 * TO) begin
         @(posedge clock); #1;
         t++;
      end
   endtask

   logic [9:0] rx;
   int         inh;
   logic       st, rts, acc2, acc3;
   logic [7:0] rb;
   logic       rack;
   int         rhalf;

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("reset_state", {27'd0, busy, ps_clock_oe, ps_data_oe, done, error}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);

      run_xfer(8'hED, 20, 1'b1, 11, rx, inh, st, rts);
      chk("ED_rts", {31'd0, rts}, 32'd1);
      chk("ED_inhibit_len", inh, INH);
      chk("ED_start_bit", {31'd0, st}, 32'd1);
      chk("ED_frame", {22'd0, rx}, 32'h3ED);
      chk("ED_error", {31'd0, error}, 32'd0);

      run_xfer(8'hF4, 12, 1'b1, 11, rx, inh, st, rts);
      chk("F4_frame", {22'd0, rx}, 32'h2F4);
      chk("F4_inhibit_len", inh, INH);

      run_xfer(8'hA5, 15, 1'b0, 11, rx, inh, st, rts);
      chk("nack_frame", {22'd0, rx}, 32'h3A5);
      chk("nack_error", {31'd0, error}, 32'd1);
      chk("nack_lines", {30'd0, ps_clock_oe, ps_data_oe}, 32'd0);

      run_xfer(8'h12, 10, 1'b1, 0, rx, inh, st, rts);
      chk("timeout_rts", {31'd0, rts}, 32'd1);
      chk("timeout_after", {28'd0, busy, ps_clock_oe, ps_data_oe, error}, 32'd1);

      fork
         run_xfer(8'hFF, 15, 1'b1, 11, rx, inh, st, rts);
         begin
            repeat (150) @(posedge clock);
            pulse_send(8'h00, acc2);
         end
      join
      $display("note: mid-transfer send accepted by model = %0d", acc2);
      chk("ignored_send_frame", {22'd0, rx}, 32'h3FF);
      chk("ignored_send_error", {31'd0, error}, 32'd0);

      for (int n = 0; n < 6; n++) begin
         rb    = 8'($urandom);
         rhalf = $urandom_range(6, 25);
         rack  = ($urandom_range(0, 3) != 0);
         run_xfer(rb, rhalf, rack, 11, rx, inh, st, rts);
         chk("rand_data", {24'd0, rx[7:0]}, {24'd0, rb});
         chk("rand_parity", {31'd0, rx[8]}, {31'd0, (($countones(rb) % 2) == 0)});
         chk("rand_stop", {31'd0, rx[9]}, 32'd1);
         chk("rand_error", {31'd0, error}, {31'd0, ~rack});
      end

      pulse_send(8'h3C, acc3);
      device(3, 10, 1'b1, rx, inh, st, rts);
      repeat (5) @(posedge clock);
      #3;
      reset_n    = 1'b0;
      m_act      = 1'b0;
      m_err_hold = 1'b0;
      #1;
      chk("async_reset_lines", {29'd0, busy, ps_clock_oe, ps_data_oe}, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clock);

      run_xfer(8'hFF, 18, 1'b1, 11, rx, inh, st, rts);
      chk("post_reset_frame", {22'd0, rx}, 32'h3FF);
      chk("post_reset_error", {31'd0, error}, 32'd0);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      repeat (5) @(posedge clock);
      $display("note: reset-test send accepted by model = %0d", acc3);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
